// File: rtl/global_buffer_param.sv
// rtl/global_buffer_param.sv - bank geometry shared by global buffer blocks
// Purpose: bank address/data widths and bank read latency.
// Ports: none (package).
package global_buffer_param;

  localparam int BANK_ADDR_WIDTH = 17;
  localparam int BANK_DATA_WIDTH = 64;
  localparam int BANK_RD_LATENCY = 3;

endpackage

// File: rtl/global_buffer_pkg.sv
// rtl/global_buffer_pkg.sv - shared types for global buffer blocks
// Purpose: bank request record carried from a requester to the bank port.
// Ports: none (package).
package global_buffer_pkg;

  import global_buffer_param::*;

  typedef struct packed {
    logic                       wr;
    logic [BANK_ADDR_WIDTH-1:0] addr;
    logic [BANK_DATA_WIDTH-1:0] data;
    logic [BANK_DATA_WIDTH-1:0] bit_sel;
  } bank_req_t;

endpackage

// File: rtl/glb_rr_arbiter.sv
// rtl/glb_rr_arbiter.sv - combinational round-robin grant selection
// Purpose: picks the first set request at or after ptr, wrapping N-1 -> 0.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    index with highest priority this cycle (< NUM_REQ)
//   grant out NUM_REQ  one-hot grant, all-zero when req is all-zero
module glb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glb_bank_arbiter.sv
// rtl/glb_bank_arbiter.sv - round-robin arbiter sharing one bank among requesters
// Purpose: grants one eligible requester per cycle, registers its access onto
//   the bank port and routes read data back to the originating requester.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cfg_req_en     in  NUM_REQ    per-requester enable
//   req_valid/req_wr in NUM_REQ   pending access / write flag
//   req_addr       in  NUM_REQ*AW byte address slices
//   req_data, req_bit_sel in NUM_REQ*DW write data / bit enable slices
//   req_ready      out NUM_REQ    one-hot grant
//   mem_ren/mem_wen out           bank strobes, one cycle after acceptance
//   mem_addr, mem_data_in, mem_bit_sel out  bank request fields
//   mem_data_out   in  DW         bank data, RD_LATENCY cycles after mem_ren
//   rd_valid       out NUM_REQ    one-hot read response strobe
//   rd_data        out DW         read response data, 0 when no response
module glb_bank_arbiter
  import global_buffer_param::*;
  import global_buffer_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int RD_LATENCY = BANK_RD_LATENCY
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 cfg_req_en,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_wr,
  input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0] req_bit_sel,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               mem_ren,
  output logic                               mem_wen,
  output logic [BANK_ADDR_WIDTH-1:0]         mem_addr,
  output logic [BANK_DATA_WIDTH-1:0]         mem_data_in,
  output logic [BANK_DATA_WIDTH-1:0]         mem_bit_sel,
  input  logic [BANK_DATA_WIDTH-1:0]         mem_data_out,
  output logic [NUM_REQ-1:0]                 rd_valid,
  output logic [BANK_DATA_WIDTH-1:0]         rd_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   ptr_next;
  bank_req_t          sel_req;
  logic               accept;

  // Response pipeline: stage 0 lines up with mem_ren, stage RD_LATENCY with
  // the cycle mem_data_out carries that read's data.
  logic [RD_LATENCY:0] pipe_vld;
  logic [PTR_W-1:0]    pipe_id [RD_LATENCY:0];

  assign eligible = req_valid & cfg_req_en;

  glb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = reset ? '0 : grant;
  // req_ready is only set for eligible (hence valid) requesters.
  assign accept    = |req_ready;

  always_comb begin
    sel_idx = '0;
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx         = PTR_W'(i);
        sel_req.wr      = req_wr[i];
        sel_req.addr    = req_addr[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
        sel_req.data    = req_data[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
        sel_req.bit_sel = req_bit_sel[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
      end
    end
  end

  assign ptr_next = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_bit_sel <= '0;
    end else begin
      if (accept) begin
        ptr <= ptr_next;
      end
      mem_ren     <= accept & ~sel_req.wr;
      mem_wen     <= accept & sel_req.wr;
      mem_addr    <= accept ? sel_req.addr : '0;
      mem_data_in <= (accept && sel_req.wr) ? sel_req.data : '0;
      mem_bit_sel <= (accept && sel_req.wr) ? sel_req.bit_sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int k = 0; k <= RD_LATENCY; k++) begin
        pipe_id[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= accept & ~sel_req.wr;
      pipe_id[0]  <= sel_idx;
      for (int k = 1; k <= RD_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

  // Gated by reset so an in-flight read cannot surface while reset is held.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (pipe_vld[RD_LATENCY] && !reset) begin
      rd_valid[pipe_id[RD_LATENCY]] = 1'b1;
      rd_data                       = mem_data_out;
    end
  end

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// tb/tb_glb_bank_arbiter.sv - scoreboard bench for glb_bank_arbiter
module tb_glb_bank_arbiter;

  import global_buffer_param::*;

  localparam int N  = 4;
  localparam int L  = BANK_RD_LATENCY;
  localparam int AW = BANK_ADDR_WIDTH;
  localparam int DW = BANK_DATA_WIDTH;

  logic              clk;
  logic              reset;
  logic [N-1:0]      cfg_req_en;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_wr;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N*DW-1:0]   req_bit_sel;
  logic [N-1:0]      req_ready;
  logic              mem_ren;
  logic              mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data_in;
  logic [DW-1:0]     mem_bit_sel;
  logic [DW-1:0]     mem_data_out;
  logic [N-1:0]      rd_valid;
  logic [DW-1:0]     rd_data;

  glb_bank_arbiter #(.NUM_REQ(N), .RD_LATENCY(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_req_en   (cfg_req_en),
    .req_valid    (req_valid),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_bit_sel  (req_bit_sel),
    .req_ready    (req_ready),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_bit_sel  (mem_bit_sel),
    .mem_data_out (mem_data_out),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    return {16'hD00D, 16'(i), 32'(i * 13 + 5)};
  endfunction

  // Bank model: writes commit at the edge, reads appear L cycles after mem_ren.
  logic          bank_load;
  logic [DW-1:0] bank [0:1023];
  logic [DW-1:0] dly  [1:L];

  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 1024; i++) bank[i] <= init_val(i);
    end else if (mem_wen) begin
      bank[mem_addr[9:0]] <= (bank[mem_addr[9:0]] & ~mem_bit_sel) | (mem_data_in & mem_bit_sel);
    end
    dly[1] <= mem_ren ? bank[mem_addr[9:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 2; k <= L; k++) dly[k] <= dly[k-1];
  end
  assign mem_data_out = dly[L];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  typedef struct {
    int            id;
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] shadow [0:1023];
  int            cyc   = 0;
  int            ptr_m = 0;

  // Stimulus for the next tick.
  logic          rst_v;
  logic [N-1:0]  valid_v, wr_v, en_v;
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  logic [DW-1:0] bs_a   [N];

  // Bank-port expectation for the current cycle.
  logic          cur_ren, cur_wen, cur_strict;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_din, cur_bs;

  task automatic tick();
    logic [N-1:0]  eg;
    logic [63:0]   one_hot;
    int            gi;
    int            a;
    rsp_t          e;
    @(negedge clk);
    cyc++;
    check("mem_strobes", {62'd0, mem_ren, mem_wen}, {62'd0, cur_ren, cur_wen});
    if (cur_ren || cur_wen || cur_strict) begin
      check("mem_addr", 64'(mem_addr), 64'(cur_addr));
      check("mem_data_in", mem_data_in, cur_din);
      check("mem_bit_sel", mem_bit_sel, cur_bs);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      one_hot = 64'd1 << e.id;
      check("rd_valid", 64'(rd_valid), one_hot);
      check("rd_data", rd_data, e.data);
    end else begin
      check("rd_valid_idle", 64'(rd_valid), 64'd0);
      check("rd_data_idle", rd_data, 64'd0);
    end

    reset      = rst_v;
    req_valid  = valid_v;
    req_wr     = wr_v;
    cfg_req_en = en_v;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]    = addr_a[i];
      req_data[i*DW +: DW]    = data_a[i];
      req_bit_sel[i*DW +: DW] = bs_a[i];
    end
    #1;

    eg = '0;
    gi = -1;
    if (!rst_v) begin
      for (int k = 0; k < N; k++) begin
        if (gi < 0 && valid_v[(ptr_m + k) % N] && en_v[(ptr_m + k) % N]) gi = (ptr_m + k) % N;
      end
      if (gi >= 0) eg[gi] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(eg));

    cur_ren = 1'b0; cur_wen = 1'b0; cur_strict = 1'b0;
    cur_addr = '0; cur_din = '0; cur_bs = '0;
    if (rst_v) begin
      ptr_m = 0;
      q.delete();
      cur_strict = 1'b1;
    end else if (gi >= 0) begin
      a = int'(addr_a[gi][9:0]);
      cur_addr = addr_a[gi];
      if (wr_v[gi]) begin
        cur_wen = 1'b1;
        cur_din = data_a[gi];
        cur_bs  = bs_a[gi];
        shadow[a] = (shadow[a] & ~bs_a[gi]) | (data_a[gi] & bs_a[gi]);
      end else begin
        cur_ren = 1'b1;
        e.id = gi; e.cyc = cyc + 1 + L; e.data = shadow[a];
        q.push_back(e);
      end
      ptr_m = (gi + 1) % N;
    end
    bank_load = 1'b0;
  endtask

  task automatic set_idle();
    valid_v = '0; wr_v = '0; en_v = '1; rst_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0; data_a[i] = '0; bs_a[i] = '0;
    end
  endtask

  task automatic all_reads(input logic [N-1:0] en);
    valid_v = '1; wr_v = '0; en_v = en;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'((cyc * 4 + i * 3) & 10'h3ff);
      data_a[i] = {$urandom, $urandom};
      bs_a[i]   = {$urandom, $urandom};
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    bank_load  = 1'b1;
    reset      = 1'b1;
    cfg_req_en = '0; req_valid = '0; req_wr = '0;
    req_addr = '0; req_data = '0; req_bit_sel = '0;
    cur_ren = 1'b0; cur_wen = 1'b0; cur_strict = 1'b0;
    cur_addr = '0; cur_din = '0; cur_bs = '0;
    set_idle();

    // Reset held: everything idle, nothing granted even with requests pending.
    rst_v = 1'b1; valid_v = '1;
    repeat (2) tick();
    set_idle();
    tick();

    // All requesters reading back to back: rotation 0,1,2,3,0,...
    for (int t = 0; t < 10; t++) begin all_reads('1); tick(); end
    set_idle();

    // Full write then read of the same address; then a partial-mask write.
    valid_v = 4'b0100; wr_v = 4'b0100;
    addr_a[2] = 17'h40; data_a[2] = 64'hA5A5; bs_a[2] = '1;
    tick();
    set_idle();
    valid_v = 4'b0010; addr_a[1] = 17'h40;
    tick();
    set_idle();
    valid_v = 4'b0001; wr_v = 4'b0001;
    addr_a[0] = 17'h41; data_a[0] = 64'h1111_2222_3333_4444; bs_a[0] = 64'h0000_FFFF_0000_FFFF;
    tick();
    set_idle();
    valid_v = 4'b1000; addr_a[3] = 17'h41;
    tick();
    set_idle();

    // Requester 2 disabled: rotation skips it.
    for (int t = 0; t < 8; t++) begin all_reads(4'b1011); tick(); end
    set_idle();

    // Move pointer to 3, then only 3 and 0 pending: 3 then 0.
    valid_v = 4'b0100; tick();
    valid_v = 4'b1001; tick(); tick();
    set_idle();
    repeat (5) tick();

    // Read from 1, then disable 1 while its read is in flight.
    valid_v = 4'b0010; addr_a[1] = 17'h7; tick();
    valid_v = 4'b0000; en_v = 4'b1101; tick();
    repeat (5) tick();
    set_idle();

    // Two reads in flight, then reset: responses dropped.
    all_reads('1); tick(); tick();
    set_idle(); rst_v = 1'b1; valid_v = '1;
    repeat (2) tick();
    set_idle();
    repeat (6) tick();

    // Random mix of reads, writes, enables.
    for (int t = 0; t < 40; t++) begin
      valid_v = N'($urandom); wr_v = N'($urandom); en_v = N'($urandom | 32'h1);
      for (int i = 0; i < N; i++) begin
        addr_a[i] = AW'($urandom_range(0, 15) + 32'h80);
        data_a[i] = {$urandom, $urandom};
        bs_a[i]   = {$urandom, $urandom};
      end
      tick();
    end
    set_idle();
    repeat (L + 3) tick();
    check("drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/glb_bank_arbiter.md
GLB_BANK_ARBITER -- requirements
Module: glb_bank_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one bank memory (2..8).
REQ-002 Parameter RD_LATENCY, default 3, cycles from bank ren to valid bank data_out; equals global_buffer_param BANK_RD_LATENCY.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_req_en  input  NUM_REQ  per-requester enable; disabled requester never granted.
REQ-006 req_valid  input  NUM_REQ  requester i has a pending access.
REQ-007 req_wr  input  NUM_REQ  1=write, 0=read, per requester.
REQ-008 req_addr  input  NUM_REQ*BANK_ADDR_WIDTH  byte address, slice i for requester i.
REQ-009 req_data  input  NUM_REQ*BANK_DATA_WIDTH  write data, slice i.
REQ-010 req_bit_sel  input  NUM_REQ*BANK_DATA_WIDTH  write bit enables, slice i.
REQ-011 req_ready  output  NUM_REQ  one-hot grant; request i accepted when req_valid[i]&req_ready[i].
REQ-012 mem_ren, mem_wen  output  1 each  bank read/write strobes.
REQ-013 mem_addr  output  BANK_ADDR_WIDTH  bank byte address.
REQ-014 mem_data_in, mem_bit_sel  output  BANK_DATA_WIDTH each  bank write data and bit enables.
REQ-015 mem_data_out  input  BANK_DATA_WIDTH  bank read data, valid RD_LATENCY cycles after mem_ren.
REQ-016 rd_valid  output  NUM_REQ  one-hot read-response strobe to originating requester.
REQ-017 rd_data  output  BANK_DATA_WIDTH  read response data, shared by all requesters.

Function
REQ-018 Eligible set = req_valid & cfg_req_en; at most one bit of req_ready SHALL be set per cycle, combinationally from the eligible set and the priority pointer.
REQ-019 Round-robin: grant goes to first eligible index at or after pointer, searching upward with wrap N-1 -> 0.
REQ-020 After a grant to i, pointer SHALL become (i+1) mod NUM_REQ; no grant -> pointer unchanged.
REQ-021 req_ready[i] SHALL be 0 whenever eligible[i] is 0.
REQ-022 Accepted request SHALL be registered: mem_ren/mem_wen, mem_addr, mem_data_in, mem_bit_sel asserted exactly 1 cycle after acceptance, for exactly 1 cycle.
REQ-023 mem_ren and mem_wen SHALL never both be 1; both 0 in cycles without a preceding acceptance; mem_data_in/mem_bit_sel SHALL be 0 for reads.
REQ-024 Read accepted in cycle T: rd_valid[i]=1 and rd_data=mem_data_out in cycle T+1+RD_LATENCY (default T+4), for one cycle.
REQ-025 Requester ID and read flag SHALL travel a RD_LATENCY+1 deep shift pipeline; back-to-back reads every cycle SHALL be supported with no bubbles.
REQ-026 Writes produce no response.
REQ-027 rd_data SHALL be 0 when rd_valid is all-zero.
REQ-028 Clearing cfg_req_en[i] SHALL not cancel in-flight reads of i; their responses still return.

Reset
REQ-029 On reset: pointer=0, all pipeline stages cleared, mem_ren=mem_wen=0, mem_addr/mem_data_in/mem_bit_sel=0, rd_valid=0, rd_data=0.
REQ-030 Reset mid-operation SHALL drop all in-flight reads (no rd_valid after reset) and req_ready SHALL be 0 while reset is high.

Structure
REQ-031 BANK_ADDR_WIDTH, BANK_DATA_WIDTH, BANK_RD_LATENCY belong in global_buffer_param; request struct typedef (wr, addr, data, bit_sel) in global_buffer_pkg.
REQ-032 Round-robin grant logic SHALL be a sub-module glb_rr_arbiter (request vector, pointer in, one-hot grant out).

Verification
REQ-033 All 4 requesters read continuously from reset -> grants 0,1,2,3,0,... one per cycle; rd_valid of requester 0 first at cycle 4 after first acceptance.
REQ-034 Req 2 writes addr 0x40 data 0xA5A5, bit_sel all-ones, then req 1 reads 0x40 -> mem_wen then mem_ren one cycle apart; rd_valid[1] with rd_data 0xA5A5.
REQ-035 cfg_req_en=4'b1011, all valid -> requester 2 never granted; others rotate 0,1,3.
REQ-036 Pointer at 3, only req 3 and req 0 valid -> grant 3 then 0 (wrap).
REQ-037 Reads accepted in cycles 5,6; reset in cycle 7 -> no rd_valid in any later cycle, all outputs 0 during reset.
REQ-038 Req 1 read accepted, cfg_req_en[1] cleared next cycle -> rd_valid[1] still asserted at acceptance+4.
